// File: rtl/queue_output_arbiter_pkg.sv
// Shared types for the router output-port arbiter: stream types, arbitration
// classes, FSM states and the round-robin scan helper.
package queue_output_arbiter_pkg;

  localparam int AXIS_DATA_WIDTH = 32;
  localparam int ID_WIDTH        = 4;
  localparam int DEST_WIDTH      = 4;
  localparam int USER_WIDTH      = 1;
  localparam int MAX_PORTS       = 16;

  typedef struct packed {
    logic                       tvalid;
    logic [AXIS_DATA_WIDTH-1:0] tdata;
    logic                       tlast;
    logic [ID_WIDTH-1:0]        tid;
    logic [DEST_WIDTH-1:0]      tdest;
    logic [USER_WIDTH-1:0]      tuser;
  } axis_mosi_t;

  typedef struct packed {
    logic tready;
  } axis_miso_t;

  typedef enum logic [1:0] {CLASS_STARVED, CLASS_URGENT, CLASS_NORMAL} arb_class_e;
  typedef enum logic {IDLE, GRANT} arb_state_e;

  typedef struct packed {
    logic       found;
    logic [3:0] idx;
  } rr_pick_t;

  // First set bit of mask scanning upward from ptr+1, wrapping at n.
  function automatic rr_pick_t rr_pick(input logic [MAX_PORTS-1:0] mask,
                                       input logic [3:0] ptr, input int n);
    rr_pick_t   res;
    logic [4:0] cand;
    res = '0;
    for (int k = 1; k <= MAX_PORTS; k++) begin
      cand = 5'(ptr) + 5'(k);
      if (cand >= 5'(n)) cand = cand - 5'(n);
      if (!res.found && (k <= n) && mask[cand[3:0]]) begin
        res.found = 1'b1;
        res.idx   = cand[3:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/queue_output_arbiter_rr_priority_picker.sv
// Round-robin picker: given a request mask and the last winner, returns the
// next winner as index and one-hot.
module queue_output_arbiter_rr_priority_picker
  import queue_output_arbiter_pkg::*;
#(
  parameter int N  = 5,
  parameter int PW = 3
) (
  input  logic [N-1:0]  mask,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [PW-1:0] idx,
  output logic          found
);

  rr_pick_t pick;

  always_comb begin
    pick   = rr_pick(MAX_PORTS'(mask), 4'(ptr), N);
    found  = pick.found;
    idx    = PW'(pick.idx);
    onehot = '0;
    if (pick.found) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/queue_output_arbiter.sv
// Packet-granular arbiter of router input queues onto one output link, with
// occupancy-based urgency and starvation promotion.
//   state | meaning
//   IDLE  | no packet in flight, arbitrate every cycle
//   GRANT | granted queue's packet is forwarded until its last beat
module queue_output_arbiter
  import queue_output_arbiter_pkg::*;
#(
  parameter int N_PORTS      = 5,
  parameter int STARVE_LIMIT = 8
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  axis_mosi_t         in_mosi_i [N_PORTS],
  output axis_miso_t         in_miso_o [N_PORTS],
  input  logic [N_PORTS-1:0] empty_i,
  input  logic [N_PORTS-1:0] half_full_i,
  input  logic [N_PORTS-1:0] full_i,
  output axis_mosi_t         out_mosi_o,
  input  axis_miso_t         out_miso_i,
  output logic [N_PORTS-1:0] grant_o,
  output logic               busy_o
);

  localparam int PW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  arb_state_e         state, state_nxt;
  arb_class_e         sel_class;
  logic [PW-1:0]      grant_idx, rr_ptr, win_idx;
  logic [CW-1:0]      wait_cnt [N_PORTS];
  logic [N_PORTS-1:0] req, starved, urgent, sel_mask, win_onehot;
  logic               win_found, last_hs, arb_point, do_grant;
  axis_mosi_t         granted;

  always_comb begin
    req     = '0;
    starved = '0;
    urgent  = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      req[i]     = in_mosi_i[i].tvalid & ~empty_i[i];
      starved[i] = req[i] & (wait_cnt[i] == LIMIT);
      urgent[i]  = req[i] & (half_full_i[i] | full_i[i]);
    end
    if (|starved)     sel_class = CLASS_STARVED;
    else if (|urgent) sel_class = CLASS_URGENT;
    else              sel_class = CLASS_NORMAL;
    case (sel_class)
      CLASS_STARVED: sel_mask = starved;
      CLASS_URGENT:  sel_mask = urgent;
      default:       sel_mask = req;
    endcase
  end

  queue_output_arbiter_rr_priority_picker #(.N(N_PORTS), .PW(PW)) u_picker (
    .mask   (sel_mask),
    .ptr    (rr_ptr),
    .onehot (win_onehot),
    .idx    (win_idx),
    .found  (win_found)
  );

  // Reset gating keeps the link quiet the instant rst_n_i falls.
  always_comb begin
    granted    = in_mosi_i[grant_idx];
    out_mosi_o = '0;
    for (int i = 0; i < N_PORTS; i++) in_miso_o[i] = '0;
    if ((state == GRANT) && rst_n_i) begin
      out_mosi_o                  = granted;
      in_miso_o[grant_idx].tready = out_miso_i.tready;
    end
    last_hs   = (state == GRANT) & granted.tvalid & granted.tlast & out_miso_i.tready;
    arb_point = (state == IDLE) | last_hs;
    do_grant  = arb_point & win_found;
    state_nxt = state;
    if (arb_point) state_nxt = win_found ? GRANT : IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state     <= IDLE;
      grant_o   <= '0;
      grant_idx <= '0;
      rr_ptr    <= PW'(N_PORTS - 1);
      for (int i = 0; i < N_PORTS; i++) wait_cnt[i] <= '0;
    end else begin
      state <= state_nxt;
      if (do_grant) begin
        grant_o   <= win_onehot;
        grant_idx <= win_idx;
        rr_ptr    <= win_idx;
        for (int i = 0; i < N_PORTS; i++) begin
          if (PW'(i) == win_idx)                   wait_cnt[i] <= '0;
          else if (req[i] && wait_cnt[i] != LIMIT) wait_cnt[i] <= wait_cnt[i] + 1'b1;
        end
      end else if (arb_point) begin
        grant_o <= '0;
      end
    end
  end

  assign busy_o = (state == GRANT);

endmodule

// File: tb/tb_queue_output_arbiter.sv
// Randomized and directed bench for queue_output_arbiter with a rule-level
// arbitration model and per-port expected-beat scoreboard.
module tb_queue_output_arbiter;
  import queue_output_arbiter_pkg::*;

  localparam int N     = 5;
  localparam int LIMIT = 8;

  logic       clk, rst_n;
  axis_mosi_t in_mosi [N];
  axis_miso_t in_miso [N];
  logic [N-1:0] empty, half_full, full, grant;
  axis_mosi_t out_mosi;
  axis_miso_t out_miso;
  logic       busy;

  queue_output_arbiter #(.N_PORTS(N), .STARVE_LIMIT(LIMIT)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .in_mosi_i   (in_mosi),
    .in_miso_o   (in_miso),
    .empty_i     (empty),
    .half_full_i (half_full),
    .full_i      (full),
    .out_mosi_o  (out_mosi),
    .out_miso_i  (out_miso),
    .grant_o     (grant),
    .busy_o      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        last;
    logic        first;
  } beat_t;

  beat_t src_q [N][$];
  beat_t exp_q [N][$];

  int vectors = 0, miscompares = 0, seq = 0;
  int vprob = 100, rdy_prob = 100, hf_prob = 0, emp_glitch = 0;
  logic [N-1:0] hf_force = '0;
  logic [N-1:0] cons;
  int rdy_pat[$];
  logic [63:0] grant_code;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, required 0x%0h, at %0t", name, act, exp, $time);
    end
  endtask

  task automatic send_pkt(input int p, input int len);
    beat_t b;
    for (int k = 0; k < len; k++) begin
      b.data  = {p[7:0], seq[23:0]};
      b.last  = (k == len - 1);
      b.first = (k == 0);
      seq++;
      src_q[p].push_back(b);
      exp_q[p].push_back(b);
    end
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < N; i++)
      if (src_q[i].size() != 0 || exp_q[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic flush_all();
    for (int i = 0; i < N; i++) begin
      src_q[i].delete();
      exp_q[i].delete();
    end
  endtask

  // Queue-side behaviour: empty asserts once nothing remains behind the
  // final beat being presented, so a finishing tail does not re-request.
  task automatic drive_inputs();
    logic v;
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() == 0)               v = 1'b0;
      else if (cons[i] || !in_mosi[i].tvalid) v = ($urandom_range(0, 99) < vprob);
      else                                    v = 1'b1;
      in_mosi[i]        = '0;
      in_mosi[i].tvalid = v;
      in_mosi[i].tid    = 4'(i);
      if (src_q[i].size() != 0) begin
        in_mosi[i].tdata = src_q[i][0].data;
        in_mosi[i].tlast = src_q[i][0].last;
      end
      empty[i] = (src_q[i].size() == 0) || (src_q[i].size() == 1 && !src_q[i][0].first)
                 || ($urandom_range(0, 99) < emp_glitch);
      half_full[i] = hf_force[i] | ($urandom_range(0, 99) < hf_prob);
      full[i]      = ($urandom_range(0, 199) < hf_prob);
    end
    if (rdy_pat.size() != 0) out_miso.tready = (rdy_pat.pop_front() != 0);
    else                     out_miso.tready = ($urandom_range(0, 99) < rdy_prob);
  endtask

  initial begin : driver
    for (int i = 0; i < N; i++) in_mosi[i] = '0;
    empty = '1; half_full = '0; full = '0; out_miso = '0; cons = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) cons[i] = rst_n && in_mosi[i].tvalid && in_miso[i].tready;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++)
        if (cons[i] && src_q[i].size() != 0) void'(src_q[i].pop_front());
      drive_inputs();
    end
  end

  // Reference model: busy flag, granted port, last winner and loss counts.
  int   m_busy, m_g, m_rr;
  int   m_wait [N];
  logic [N-1:0] prev_grant;

  always @(negedge clk) begin : monitor
    logic [N-1:0] eg, erdy, rdy_vec, areq, cand;
    logic         ev, hs;
    int           w, p;
    beat_t        b;
    if (!rst_n) begin
      m_busy = 0; m_g = 0; m_rr = N - 1;
      for (int i = 0; i < N; i++) m_wait[i] = 0;
      grant_code = '0;
      prev_grant = '0;
      chk("reset_grant", 64'(grant), 64'(0));
      chk("reset_busy", 64'(busy), 64'(0));
    end else begin
      eg = '0;
      if (m_busy != 0) eg[m_g] = 1'b1;
      chk("grant", 64'(grant), 64'(eg));
      chk("busy", 64'(busy), 64'(m_busy != 0));
      ev = (m_busy != 0) && in_mosi[m_g].tvalid;
      chk("out_tvalid", 64'(out_mosi.tvalid), 64'(ev));
      erdy = '0;
      if (m_busy != 0 && out_miso.tready) erdy[m_g] = 1'b1;
      for (int i = 0; i < N; i++) rdy_vec[i] = in_miso[i].tready;
      chk("in_tready", 64'(rdy_vec), 64'(erdy));
      hs = ev && out_miso.tready;
      if (hs) begin
        if (exp_q[m_g].size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL unexpected_beat: port %0d sent 0x%0h, required no beat", m_g, out_mosi.tdata);
        end else begin
          b = exp_q[m_g].pop_front();
          chk("out_tdata", 64'(out_mosi.tdata), 64'(b.data));
          chk("out_tlast", 64'(out_mosi.tlast), 64'(b.last));
        end
      end
      if (grant != prev_grant && grant != '0)
        for (int i = 0; i < N; i++) if (grant[i]) grant_code = (grant_code << 3) | 64'(i + 1);
      prev_grant = grant;
      if (m_busy == 0 || (hs && in_mosi[m_g].tlast)) begin
        for (int i = 0; i < N; i++) areq[i] = in_mosi[i].tvalid && !empty[i];
        cand = '0;
        for (int i = 0; i < N; i++) if (areq[i] && m_wait[i] == LIMIT) cand[i] = 1'b1;
        if (cand == '0)
          for (int i = 0; i < N; i++) if (areq[i] && (half_full[i] || full[i])) cand[i] = 1'b1;
        if (cand == '0) cand = areq;
        w = -1;
        for (int k = 1; k <= N; k++) begin
          p = (m_rr + k) % N;
          if (w < 0 && cand[p]) w = p;
        end
        if (w >= 0) begin
          for (int i = 0; i < N; i++)
            if (areq[i] && i != w && m_wait[i] < LIMIT) m_wait[i]++;
          m_wait[w] = 0;
          m_rr = w; m_g = w; m_busy = 1;
        end else begin
          m_busy = 0;
        end
      end
    end
  end

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while (!all_empty() && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (!all_empty()) begin
      vectors++; miscompares++;
      $display("FAIL %s: drain timeout after %0d cycles, beats still outstanding, required none", name, n);
      flush_all();
    end
    repeat (3) @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    flush_all();
    hf_force = '0;
    rdy_pat.delete();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #2;
  endtask

  initial begin : stimulus
    int n;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #2;

    send_pkt(2, 3);
    wait_drain("single", 200);
    chk("single_order", grant_code, 64'o3);

    do_reset();
    for (int r = 0; r < 2; r++) begin
      send_pkt(0, 2); send_pkt(1, 2); send_pkt(3, 2);
    end
    wait_drain("round_robin", 300);
    chk("rr_order", grant_code, 64'o124124);

    do_reset();
    send_pkt(3, 2);
    wait_drain("urgency_setup", 200);
    hf_force[4] = 1'b1;
    send_pkt(0, 2); send_pkt(4, 2);
    wait_drain("urgency", 200);
    chk("urgency_order", grant_code, 64'o451);

    do_reset();
    hf_force = 5'b01100;
    send_pkt(1, 2);
    for (int r = 0; r < 6; r++) begin
      send_pkt(2, 2); send_pkt(3, 2);
    end
    wait_drain("starvation", 400);
    chk("starve_order", grant_code, 64'o3434343423434);
    hf_force = '0;

    do_reset();
    send_pkt(1, 4);
    rdy_pat.push_back(1); rdy_pat.push_back(1); rdy_pat.push_back(0);
    rdy_pat.push_back(0); rdy_pat.push_back(1);
    repeat (2) @(posedge clk);
    #2;
    hf_force[3] = 1'b1;
    send_pkt(3, 2);
    wait_drain("backpressure", 200);
    chk("backpressure_order", grant_code, 64'o24);
    hf_force = '0;

    do_reset();
    send_pkt(1, 4);
    n = 0;
    while (exp_q[1].size() > 3 && n < 100) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (exp_q[1].size() > 3) begin
      vectors++; miscompares++;
      $display("FAIL midpkt_setup: first beat never accepted, %0d beats left, required 3", exp_q[1].size());
    end
    rst_n = 1'b0;
    #1;
    chk("rst_out_tvalid", 64'(out_mosi.tvalid), 64'(0));
    for (int i = 0; i < N; i++) chk("rst_in_tready", 64'(in_miso[i].tready), 64'(0));
    flush_all();
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #2;
    send_pkt(0, 2);
    wait_drain("after_reset", 200);
    chk("after_reset_order", grant_code, 64'o1);

    vprob = 80; rdy_prob = 65; hf_prob = 25; emp_glitch = 4;
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk);
      #2;
      if ($urandom_range(0, 99) < 35) begin
        int p, len;
        p   = $urandom_range(0, N - 1);
        len = $urandom_range(1, 4);
        if (src_q[p].size() < 12) begin
          send_pkt(p, len);
          if (len == 1) send_pkt(p, $urandom_range(2, 4));
        end
      end
    end
    vprob = 100; rdy_prob = 100; emp_glitch = 0;
    wait_drain("random", 3000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/queue_output_arbiter.md
Name: queue_output_arbiter

Overview:
- Arbitrates N_PORTS router input queues onto one cross-router output port at AXI-Stream packet granularity.
- Uses the queues' occupancy flags (empty/half_full/full) to favour queues near overflow.
- Adds starvation protection.
- Sits between the per-input signalled queues and the output link of a router.

Parameters:
- N_PORTS, 5, number of requesting queues (N, E, S, W, local).
- STARVE_LIMIT, 8, lost arbitrations before a requester is forced to top class.
- AXIS_DATA_WIDTH / ID_WIDTH / DEST_WIDTH / USER_WIDTH, as axis types, forwarded to the axis_type include.

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  asynchronous active-low reset
- in_mosi_i  in  axis_mosi_t[N_PORTS]  queue outputs (TVALID, data incl. TLAST)
- in_miso_o  out  axis_miso_t[N_PORTS]  TREADY back to queues
- empty_i  in  N_PORTS  per-queue empty flag
- half_full_i  in  N_PORTS  per-queue above-half flag
- full_i  in  N_PORTS  per-queue full flag
- out_mosi_o  out  axis_mosi_t  output stream
- out_miso_i  in  axis_miso_t  output TREADY
- grant_o  out  N_PORTS  one-hot current grant, 0 when idle
- busy_o  out  1  packet in flight

Behaviour:
- Reset (async, rst_n_i low): state IDLE, grant_o=0, busy_o=0, rr_ptr=N_PORTS-1, all wait counters 0.
  - Combinationally during reset: out TVALID=0 and all in TREADY=0.
  - Reset mid-packet abandons the packet; no resumption.
- Request: req[i] = in_mosi_i[i].TVALID & !empty_i[i].
- Classes, highest first:
  - STARVED: req & wait_cnt==STARVE_LIMIT
  - URGENT: req & (half_full_i|full_i)
  - NORMAL: req
- Selection:
  - Choose the highest non-empty class.
  - Within it, round-robin: first set bit scanning from rr_ptr+1 modulo N_PORTS.
- Arbitration points: state IDLE, or state GRANT on a cycle where the granted last beat handshakes (TVALID&TREADY&TLAST).
- FSM:
  - IDLE: if any req, register grant=winner, rr_ptr=winner, go GRANT (1-cycle grant latency from first request); else stay.
  - GRANT: output is a combinational mux of in_mosi_i[g].
    - in_miso_o[g].TREADY = out_miso_i.TREADY; other TREADY=0.
    - On last-beat handshake: if any req from a different queue or the same one, re-grant next cycle without a bubble cycle (winner per rules, using updated rr_ptr); else go IDLE.
  - Grant never changes mid-packet. A grant with TVALID low stays held (no timeout).
- Wait counters:
  - At each arbitration point, every requesting non-winner increments, saturating at STARVE_LIMIT.
  - Winner clears to 0; non-requesters hold.
  - Width $clog2(STARVE_LIMIT+1).
- Simultaneous events: counter update and rr_ptr update use the same winner in the same cycle. Full and half_full both set is treated as URGENT.
- Outputs:
  - busy_o = state==GRANT.
  - grant_o registered, one-hot.
  - out TVALID=0 in IDLE.
- Single-beat packets (TLAST on first beat) complete in one GRANT cycle.

Decomposition:
- Shared package holds:
  - arb_class_e (STARVED/URGENT/NORMAL)
  - arb_state_e (IDLE/GRANT)
  - helper function rr_pick(mask, ptr) returning index and found flag.
- axis_mosi_t/axis_miso_t come from the existing axis_type include.
- One natural sub-module: rr_priority_picker (mask, pointer → one-hot/index), instantiated once per class or once on the class-selected mask.

Test Plan:
- Single requester: port 2 sends a 3-beat packet, out TREADY=1 → grant_o=5'b00100 one cycle after TVALID; 3 beats forwarded in order; IDLE after TLAST.
- Round-robin fairness: ports 0,1,3 continuously send 2-beat packets, no urgency → grant order 0,1,3,0,1,3; no idle cycle between packets.
- Urgency: ports 0 and 4 request, half_full_i[4]=1, rr_ptr=3 → port 4 granted first.
- Starvation: port 1 NORMAL while ports 2,3 stay URGENT → after 8 lost arbitrations, port 1 is granted next regardless of urgency; its counter resets to 0.
- Backpressure mid-packet: out TREADY toggles 1,0,0,1 during a 4-beat packet while port 3 becomes urgent → grant held on the original port until TLAST handshake; no data loss or duplication.
- Reset mid-packet: assert rst_n_i low during beat 2 → TVALID/TREADY drop immediately; after release grant_o=0, busy_o=0, and a new request is granted normally.
